// File: rtl/retire_stage_2way_if.sv
// ROB-head / retire-stage bundle: ROB head entries in,
// pop count, free-list pushes and recovery state out.
interface retire_stage_2way_if #(
  parameter int PREG_W = 6,
  parameter int AREG_N = 32,
  parameter int PC_W   = 32
);
  localparam int AREG_W = $clog2(AREG_N);

  logic [1:0]                   rob_valid;
  logic [1:0]                   rob_complete;
  logic [1:0]                   rob_has_dest;
  logic [1:0][AREG_W-1:0]       rob_areg;
  logic [1:0][PREG_W-1:0]       rob_preg;
  logic [1:0][PREG_W-1:0]       rob_told;
  logic [1:0]                   rob_mispred;
  logic [1:0][PC_W-1:0]         rob_target;
  logic [1:0]                   rob_halt;

  logic [1:0]                   retire_cnt;
  logic [1:0]                   free_valid;
  logic [1:0][PREG_W-1:0]       free_preg;
  logic                         flush;
  logic [PC_W-1:0]              redirect_pc;
  logic                         halted;
  logic [AREG_N-1:0][PREG_W-1:0] amt_out;
  logic [31:0]                  retired_count;

  modport master (
    output rob_valid, rob_complete, rob_has_dest,
    output rob_areg, rob_preg, rob_told,
    output rob_mispred, rob_target, rob_halt,
    input  retire_cnt, free_valid, free_preg,
    input  flush, redirect_pc, halted,
    input  amt_out, retired_count
  );

  modport slave (
    input  rob_valid, rob_complete, rob_has_dest,
    input  rob_areg, rob_preg, rob_told,
    input  rob_mispred, rob_target, rob_halt,
    output retire_cnt, free_valid, free_preg,
    output flush, redirect_pc, halted,
    output amt_out, retired_count
  );
endinterface

// File: rtl/retire_stage_2way.sv
// Two-wide in-order retirement: AMT update, free-list return,
// mispredict flush and sticky halt.
module retire_stage_2way #(
  parameter int PREG_W = 6,
  parameter int AREG_N = 32,
  parameter int PC_W   = 32
) (
  input  logic           clock,
  input  logic           reset,
  retire_stage_2way_if.slave bus
);
  localparam int AREG_W = $clog2(AREG_N);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_FLUSH = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nx;

  logic [1:0]      w_ret;
  logic [1:0]      w_dest;
  logic [1:0]      w_cnt;
  logic            w_last_mis;
  logic            w_last_halt;
  logic [PC_W-1:0] w_last_tgt;

  logic [AREG_N-1:0][PREG_W-1:0] r_amt;
  logic                          r_flush;
  logic                          r_halted;
  logic [PC_W-1:0]               r_pc;
  logic [31:0]                   r_count;

  // Lane 1 only follows a lane 0 that does not end the group.
  always_comb begin
    w_ret    = '0;
    w_ret[0] = (r_state == S_RUN) & ~reset
             & bus.rob_valid[0]
             & bus.rob_complete[0];
    w_ret[1] = w_ret[0]
             & ~bus.rob_mispred[0]
             & ~bus.rob_halt[0]
             & bus.rob_valid[1]
             & bus.rob_complete[1];
  end

  always_comb begin
    w_dest = '0;
    for (int i = 0; i < 2; i++)
      w_dest[i] = bus.rob_has_dest[i]
                & (bus.rob_areg[i] != '0);
  end

  always_comb begin
    w_last_mis  = 1'b0;
    w_last_halt = 1'b0;
    w_last_tgt  = bus.rob_target[0];
    if (w_ret[1]) begin
      w_last_mis  = bus.rob_mispred[1];
      w_last_halt = bus.rob_halt[1];
      w_last_tgt  = bus.rob_target[1];
    end else if (w_ret[0]) begin
      w_last_mis  = bus.rob_mispred[0];
      w_last_halt = bus.rob_halt[0];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_RUN;
    else       r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      S_RUN: begin
        if (w_last_halt)     w_state_nx = S_HALT;
        else if (w_last_mis) w_state_nx = S_FLUSH;
      end
      S_FLUSH: w_state_nx = S_RUN;
      S_HALT:  w_state_nx = S_HALT;
      default: w_state_nx = S_RUN;
    endcase
  end

  always_comb begin
    w_cnt          = {1'b0, w_ret[0]} + {1'b0, w_ret[1]};
    bus.retire_cnt = w_cnt;
    bus.free_valid = w_ret & w_dest;
    bus.free_preg  = bus.rob_told;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_flush  <= 1'b0;
      r_halted <= 1'b0;
      r_pc     <= '0;
      r_count  <= '0;
      for (int i = 0; i < AREG_N; i++)
        r_amt[i] <= PREG_W'(i);
    end else begin
      r_flush  <= (w_state_nx == S_FLUSH) & (r_state == S_RUN);
      r_halted <= r_halted | (w_state_nx == S_HALT);
      r_count  <= r_count + 32'(w_cnt);
      if (w_last_mis & ~w_last_halt)
        r_pc <= w_last_tgt;
      // Lane 1 written last so it wins on a shared areg.
      if (w_ret[0] & w_dest[0])
        r_amt[bus.rob_areg[0]] <= bus.rob_preg[0];
      if (w_ret[1] & w_dest[1])
        r_amt[bus.rob_areg[1]] <= bus.rob_preg[1];
    end
  end

  assign bus.flush         = r_flush;
  assign bus.halted        = r_halted;
  assign bus.redirect_pc   = r_pc;
  assign bus.retired_count = r_count;
  assign bus.amt_out       = r_amt;

endmodule
